fill_writer: RTL and testbench
==============================

# fill_writer

Loads a 16-entry × 8-bit operand buffer one byte at a time and serves it on a combinational read port. It is the writer side of the 4-bit-address / 8-bit-data interface that the reduce-sum datapath reads. A `start` pulse opens a fill window and bytes arrive on a valid/ready handshake. After the 16th accepted byte, the block pulses `done`, which the system uses as the `enable` for the summing stage.

## Interface
Parameters: none; depth 16 and width 8 are fixed by the read interface.

- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a fill; sampled only in IDLE
- `abort`  in  1  cancel a fill in progress; sampled only in FILL
- `in_valid`  in  1  `in_data` holds a byte
- `in_data`  in  8  byte to store
- `in_ready`  out  1  block accepts a byte this cycle
- `busy`  out  1  fill in progress
- `done`  out  1  one-cycle pulse when the fill is complete
- `wr_addr`  out  4  address of the next byte to be written
- `count`  out  5  bytes accepted in the current fill, 0..16
- `rd_addr`  in  4  read address (the summing stage's `address`)
- `rd_data`  out  8  buffer contents at `rd_addr`, combinational
- `checksum`  out  12  present only with `FILL_CHECKSUM_EN`

## Operation
States (enum): IDLE, FILL, DONE.

- **IDLE:** `in_ready`=0, `busy`=0.
  - `start`=1 → FILL; `wr_addr` and `count` clear to 0.
- **FILL:** `in_ready`=1, `busy`=1.
  - Accept when `in_valid`=1: `mem[wr_addr]` ← `in_data`, then `wr_addr`+1 and `count`+1.
  - Accept at `wr_addr`=15 → DONE. `count` becomes 16 and `wr_addr` wraps to 0.
  - `abort`=1 → IDLE. No write occurs that cycle, even if `in_valid`=1. Buffer keeps any partial contents. `count` holds its value; `done` is not asserted.
  - `start` is ignored in FILL.
  - `abort` takes priority over an accept.
- **DONE:** `done`=1, `in_ready`=0, `busy`=1 for exactly one cycle, then → IDLE.
  - `start` in DONE is ignored.
- **Read port:** `rd_data` = `mem[rd_addr]`, always, in every state.
  - Reading the entry being written in the same cycle returns the old value; the new value is visible the next cycle.
- **Reset:** asynchronous and immediate from any state.
  - State → IDLE; `wr_addr`, `count`, `done`, `in_ready`, `busy`, `checksum` → 0; all 16 buffer entries → 8'h00.
  - A fill interrupted by reset is discarded; no `done`.

## Timing
- Minimum fill is 18 cycles from `start` to `done`:
  - 1 cycle IDLE→FILL.
  - 16 accepting cycles.
  - `done` high on the cycle after the 16th accept.
- `in_ready` is decoded from state only and does not depend on `in_valid`.
- Back-to-back fills: the earliest `start` is sampled in the IDLE cycle after DONE.
- Gaps with `in_valid`=0 stall the fill without limit. There is no timeout.

## Configuration
- **`FILL_CHECKSUM_EN` defined:**
  - Adds a 12-bit `checksum` register and port.
  - Cleared on IDLE→FILL; adds the zero-extended `in_data` on every accept.
  - Cannot overflow: 16 × 255 = 4080 < 4096.
  - Stable from the `done` cycle until the next `start`.
  - Holds its partial value on abort.
- **Not defined:** no `checksum` port and no adder logic.

## Structure
- Shared package `fill_pkg`:
  - `fill_state_t` enum.
  - Constants `FILL_DEPTH`=16, `FILL_AW`=4, `FILL_DW`=8, `FILL_SUM_W`=12.
- Sub-module `regfile16x8`:
  - One synchronous write port: `we`, `waddr`, `wdata`.
  - One combinational read port.
  - Async active-low clear.
- `fill_writer` contains the FSM, the counters and the optional checksum.

## Test plan
- **Basic fill:** reset, `start`, then `in_data`=1..16 with `in_valid` held high.
  - `done` rises exactly 17 cycles after the `start` sample edge.
  - `count`=16; `rd_addr`=k reads k+1 for all k.
- **Stalls:** same data with `in_valid` deasserted every other cycle.
  - Identical buffer contents; `done` 33 cycles after `start`; `in_ready` stays high throughout FILL.
- **Abort:** abort after 5 accepts (bytes 8'hA0..8'hA4) with `in_valid`=1 on the abort cycle.
  - No `done`; `count`=5; entries 0..4 = A0..A4; entry 5 unchanged.
  - A new `start` restarts at `wr_addr`=0.
- **Reset mid-fill:** assert `reset_n`=0 asynchronously after 9 accepts.
  - Outputs go to 0 immediately, without waiting for a clock edge; all entries read 8'h00; no `done`.
- **Ignored start:** pulse `start` during FILL and during DONE.
  - No restart; `done` is a single one-cycle pulse.
- **Checksum** (`FILL_CHECKSUM_EN`): 16 × 8'hFF.
  - `checksum`=12'hFF0 at `done`.
  - Without the macro, the build elaborates with no `checksum` port.

Source files
------------

// File: rtl/fill_pkg.sv
// -----------------------------------------------------------------------------
// fill_pkg
// Shared types and constants for the operand-buffer fill writer and its
// 16 x 8 register file. Depth and width are fixed by the 4-bit-address /
// 8-bit-data read interface of the reduce-sum datapath.
// -----------------------------------------------------------------------------
package fill_pkg;

  localparam int unsigned FILL_DEPTH = 16;
  localparam int unsigned FILL_AW    = 4;
  localparam int unsigned FILL_DW    = 8;
  localparam int unsigned FILL_SUM_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fill_writer_regfile16x8.sv
// -----------------------------------------------------------------------------
// regfile16x8
// 16-entry x 8-bit register file: one synchronous write port, one
// combinational read port, asynchronous active-low clear of all entries.
// A read of the entry being written returns the old value until the edge.
//
// Ports:
//   clock    in   write clock (rising edge)
//   reset_n  in   async active-low clear, all entries -> 8'h00
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module regfile16x8
  import fill_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               we,
  input  logic [FILL_AW-1:0] waddr,
  input  logic [FILL_DW-1:0] wdata,
  input  logic [FILL_AW-1:0] raddr,
  output logic [FILL_DW-1:0] rdata
);

  logic [FILL_DW-1:0] mem_q [FILL_DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FILL_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fill_writer.sv
// -----------------------------------------------------------------------------
// fill_writer
// Loads a 16 x 8 operand buffer one byte at a time over a valid/ready
// handshake and serves it on a combinational read port. A start pulse in
// IDLE opens a fill; after the 16th accepted byte 'done' pulses for one
// cycle (used as the summing stage's enable).
//
// Optional feature: define FILL_CHECKSUM_EN to add a 12-bit running sum of
// accepted bytes on the 'checksum' port.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset_n   in   async active-low reset
//   start     in   begin a fill (sampled in IDLE only)
//   abort     in   cancel a fill (sampled in FILL only, beats an accept)
//   in_valid  in   in_data holds a byte
//   in_data   in   byte to store
//   in_ready  out  byte accepted this cycle if in_valid (FILL state only)
//   busy      out  fill in progress (FILL or DONE)
//   done      out  one-cycle pulse after the 16th accept
//   wr_addr   out  address of the next byte to be written
//   count     out  bytes accepted in the current fill, 0..16
//   rd_addr   in   read address
//   rd_data   out  buffer contents at rd_addr, combinational
//   checksum  out  sum of accepted bytes (FILL_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module fill_writer
  import fill_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [FILL_DW-1:0]    in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [FILL_AW-1:0]    wr_addr,
  output logic [FILL_AW:0]      count,
  input  logic [FILL_AW-1:0]    rd_addr,
  output logic [FILL_DW-1:0]    rd_data
`ifdef FILL_CHECKSUM_EN
  ,
  output logic [FILL_SUM_W-1:0] checksum
`endif
);

  fill_state_t          state_q, state_d;
  logic [FILL_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [FILL_AW:0]     count_q, count_d;
  logic                 we;

`ifdef FILL_CHECKSUM_EN
  logic [FILL_SUM_W-1:0] checksum_q, checksum_d;
`endif

  // Registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      count_q   <= '0;
`ifdef FILL_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      count_q   <= count_d;
`ifdef FILL_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // Next state, counters and write strobe
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    we        = 1'b0;
`ifdef FILL_CHECKSUM_EN
    checksum_d = checksum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          wr_addr_d = '0;
          count_d   = '0;
`ifdef FILL_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end

      FILL: begin
        // Abort wins over an accept in the same cycle: no write, counts hold.
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;   // wraps 15 -> 0 on the last byte
          count_d   = count_q + 1'b1;
`ifdef FILL_CHECKSUM_EN
          checksum_d = checksum_q + {{(FILL_SUM_W-FILL_DW){1'b0}}, in_data};
`endif
          if (wr_addr_q == FILL_AW'(FILL_DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/status outputs are decoded from state only.
  assign in_ready = (state_q == FILL);
  assign busy     = (state_q == FILL) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign wr_addr  = wr_addr_q;
  assign count    = count_q;

`ifdef FILL_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

  regfile16x8 u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (wr_addr_q),
    .wdata   (in_data),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_fill_writer.sv
// -----------------------------------------------------------------------------
// tb_fill_writer
// Directed bench for fill_writer: reset state, basic fill, stalled fill,
// abort, asynchronous reset mid-fill, ignored start pulses and (with
// FILL_CHECKSUM_EN) the checksum of sixteen 8'hFF bytes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fill_writer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] wr_addr;
  logic [4:0] count;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
`ifdef FILL_CHECKSUM_EN
  logic [11:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;

  fill_writer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .wr_addr  (wr_addr),
    .count    (count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef FILL_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one fill from a start pulse. cyc = index of the cycle after the
  // start sample edge in which done is seen (0 if never within the bound).
  task automatic run_fill(input bit stall, input bit ff, input bit poke,
                          output int cyc, output bit rdy_ok);
    int idx;
    idx    = 0;
    cyc    = 0;
    rdy_ok = 1'b1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        cyc = n;
        break;
      end
      if (!in_ready) rdy_ok = 1'b0;
      start = poke && (n == 3);
      if (idx < 16 && (!stall || (n % 2 == 0))) begin
        in_valid = 1'b1;
        in_data  = ff ? 8'hFF : 8'(idx + 1);
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc == 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    bit rdy_ok;
    bit saw_done;

    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 4'd0;
    step();
    step();

    // Reset state
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy",     busy,     0);
    check_eq("rst_done",     done,     0);
    check_eq("rst_wr_addr",  wr_addr,  0);
    check_eq("rst_count",    count,    0);
`ifdef FILL_CHECKSUM_EN
    check_eq("rst_checksum", checksum, 0);
`endif
    rd_addr = 4'd9;
    #1;
    check_eq("rst_rd9", rd_data, 0);
    reset_n = 1'b1;
    step();

    // Basic fill: bytes 1..16 back to back
    run_fill(1'b0, 1'b0, 1'b0, cyc, rdy_ok);
    check_eq("basic_cycles",  cyc,      17);
    check_eq("basic_count",   count,    16);
    check_eq("basic_wr_addr", wr_addr,  0);
    check_eq("basic_busy",    busy,     1);
    check_eq("basic_ready",   in_ready, 0);
    step();
    check_eq("basic_done_pulse", done, 0);
    check_eq("basic_idle_busy",  busy, 0);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      check_eq("basic_rd", rd_data, 32'(k + 1));
    end

    // Stalled fill into a freshly cleared buffer
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    run_fill(1'b1, 1'b0, 1'b0, cyc, rdy_ok);
    check_eq("stall_cycles", cyc,    33);
    check_eq("stall_ready",  rdy_ok, 1);
    check_eq("stall_count",  count,  16);
    step();
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      check_eq("stall_rd", rd_data, 32'(k + 1));
    end

    // Abort after 5 accepts, with in_valid high on the abort cycle
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'hA0 + i);
      step();
    end
    check_eq("abort_pre_count", count,   5);
    check_eq("abort_pre_waddr", wr_addr, 5);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_eq("abort_busy",  busy,     0);
    check_eq("abort_ready", in_ready, 0);
    check_eq("abort_count", count,    5);
    saw_done = done;
    repeat (3) begin
      step();
      saw_done = saw_done | done;
    end
    check_eq("abort_no_done", saw_done, 0);
    for (int k = 0; k < 5; k++) begin
      rd_addr = 4'(k);
      #1;
      check_eq("abort_rd", rd_data, 32'(32'hA0 + k));
    end
    rd_addr = 4'd5;
    #1;
    check_eq("abort_rd5_kept", rd_data, 8'h06);

    // Restart after abort begins at address 0
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart_waddr", wr_addr, 0);
    check_eq("restart_count", count,   0);
    check_eq("restart_busy",  busy,    1);
    rd_addr  = 4'd0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    check_eq("rd_old_same_cycle", rd_data, 8'hA0);
    step();
    in_valid = 1'b0;
    check_eq("rd_new_next_cycle", rd_data, 8'h55);
    check_eq("restart_waddr1",    wr_addr, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("restart_abort_busy", busy, 0);

    // Asynchronous reset after 9 accepts
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h30 + i);
      step();
    end
    in_valid = 1'b0;
    check_eq("midrst_pre_count", count, 9);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy",    busy,     0);
    check_eq("midrst_ready",   in_ready, 0);
    check_eq("midrst_done",    done,     0);
    check_eq("midrst_count",   count,    0);
    check_eq("midrst_wr_addr", wr_addr,  0);
`ifdef FILL_CHECKSUM_EN
    check_eq("midrst_checksum", checksum, 0);
`endif
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      check_eq("midrst_rd", rd_data, 0);
    end
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      step();
      saw_done = saw_done | done;
    end
    check_eq("midrst_no_done", saw_done, 0);

    // Start pulses in FILL and DONE are ignored
    run_fill(1'b0, 1'b0, 1'b1, cyc, rdy_ok);
    check_eq("ign_cycles", cyc,   17);
    check_eq("ign_count",  count, 16);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("ign_done_single", done, 0);
    check_eq("ign_idle_busy",   busy, 0);
    step();
    check_eq("ign_still_idle",  busy, 0);

    // All-0xFF fill (checksum 12'hFF0 when the feature is built in)
    run_fill(1'b0, 1'b1, 1'b0, cyc, rdy_ok);
    check_eq("ff_cycles", cyc, 17);
`ifdef FILL_CHECKSUM_EN
    check_eq("ff_checksum", checksum, 12'hFF0);
    step();
    check_eq("ff_checksum_stable", checksum, 12'hFF0);
`else
    step();
`endif
    rd_addr = 4'd7;
    #1;
    check_eq("ff_rd7", rd_data, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
